// File: rtl/uart_core.sv
// uart_core: 8N1 UART with independent transmitter and receiver.
// Each bit lasts BPC = CLK_FREQ/BAUD clocks. The receiver double-synchronizes
// rx, checks the start bit at half a bit time, and then samples each data bit
// and the stop bit at bit centre.
module uart_core #(
   parameter int CLK_FREQ = 40000000,
   parameter int BAUD     = 9600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic       tx,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       tx_busy,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ack,
   output logic       rx_frame_err,
   output logic       rx_overrun
);

   localparam int BPC = CLK_FREQ / BAUD;
   localparam int CW  = $clog2(BPC);
   localparam logic [CW-1:0] LAST = CW'(BPC - 1);
   localparam logic [CW-1:0] HALF = CW'(BPC / 2 - 1);

   typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;
   typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_BREAK} rx_state_t;

   // ---------------- transmitter ----------------
   tx_state_t     tstate, tstate_n;
   logic [CW-1:0] tcnt, tcnt_n;
   logic [2:0]    tbit, tbit_n;
   logic [7:0]    tsh, tsh_n;
   logic          tx_n;

   // TX state, bit timer, shift register and registered line driver
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tstate <= T_IDLE;
         tcnt   <= '0;
         tbit   <= '0;
         tsh    <= '0;
         tx     <= 1'b1;
      end else begin
         tstate <= tstate_n;
         tcnt   <= tcnt_n;
         tbit   <= tbit_n;
         tsh    <= tsh_n;
         tx     <= tx_n;
      end
   end

   // TX next state; tx is decoded from the next state so the line is glitch-free
   always_comb begin
      tstate_n = tstate;
      tcnt_n   = tcnt;
      tbit_n   = tbit;
      tsh_n    = tsh;
      case (tstate)
         T_IDLE: begin
            if (tx_start) begin
               tsh_n    = tx_data;
               tcnt_n   = '0;
               tstate_n = T_START;
            end
         end
         T_START: begin
            if (tcnt == LAST) begin
               tcnt_n   = '0;
               tbit_n   = '0;
               tstate_n = T_DATA;
            end else tcnt_n = tcnt + CW'(1);
         end
         T_DATA: begin
            if (tcnt == LAST) begin
               tcnt_n = '0;
               tsh_n  = {1'b0, tsh[7:1]};
               if (tbit == 3'd7) tstate_n = T_STOP;
               else              tbit_n   = tbit + 3'd1;
            end else tcnt_n = tcnt + CW'(1);
         end
         T_STOP: begin
            if (tcnt == LAST) begin
               tcnt_n   = '0;
               tstate_n = T_IDLE;
            end else tcnt_n = tcnt + CW'(1);
         end
         default: tstate_n = T_IDLE;
      endcase
      case (tstate_n)
         T_START: tx_n = 1'b0;
         T_DATA:  tx_n = tsh_n[0];
         default: tx_n = 1'b1;
      endcase
   end

   assign tx_busy = (tstate != T_IDLE);

   // ---------------- receiver ----------------
   logic          rx_s1, rxs;
   rx_state_t     rstate, rstate_n;
   logic [CW-1:0] rcnt, rcnt_n;
   logic [2:0]    rbit, rbit_n;
   logic [7:0]    rsh, rsh_n;
   logic          deliver, ferr;

   // two-flop synchronizer, reset to the idle line level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_s1 <= 1'b1;
         rxs   <= 1'b1;
      end else begin
         rx_s1 <= rx;
         rxs   <= rx_s1;
      end
   end

   // RX state, sample timer and shift register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rstate <= R_IDLE;
         rcnt   <= '0;
         rbit   <= '0;
         rsh    <= '0;
      end else begin
         rstate <= rstate_n;
         rcnt   <= rcnt_n;
         rbit   <= rbit_n;
         rsh    <= rsh_n;
      end
   end

   // RX next state: start check at half bit, then one sample per bit at centre
   always_comb begin
      rstate_n = rstate;
      rcnt_n   = rcnt;
      rbit_n   = rbit;
      rsh_n    = rsh;
      deliver  = 1'b0;
      ferr     = 1'b0;
      case (rstate)
         R_IDLE: begin
            if (!rxs) begin
               rcnt_n   = '0;
               rstate_n = R_START;
            end
         end
         R_START: begin
            if (rcnt == HALF) begin
               rcnt_n   = '0;
               rbit_n   = '0;
               rstate_n = rxs ? R_IDLE : R_DATA;
            end else rcnt_n = rcnt + CW'(1);
         end
         R_DATA: begin
            if (rcnt == LAST) begin
               rcnt_n = '0;
               rsh_n  = {rxs, rsh[7:1]};
               if (rbit == 3'd7) rstate_n = R_STOP;
               else              rbit_n   = rbit + 3'd1;
            end else rcnt_n = rcnt + CW'(1);
         end
         R_STOP: begin
            if (rcnt == LAST) begin
               rcnt_n = '0;
               if (rxs) begin
                  deliver  = 1'b1;
                  rstate_n = R_IDLE;
               end else begin
                  ferr     = 1'b1;
                  rstate_n = R_BREAK;
               end
            end else rcnt_n = rcnt + CW'(1);
         end
         R_BREAK: begin
            if (rxs) rstate_n = R_IDLE;
         end
         default: rstate_n = R_IDLE;
      endcase
   end

   // consumer-facing holding register, valid/overrun flags and error pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         rx_overrun   <= 1'b0;
         rx_frame_err <= 1'b0;
      end else begin
         rx_frame_err <= ferr;
         if (deliver) begin
            if (rx_valid && !rx_ack) begin
               rx_overrun <= 1'b1;
            end else begin
               rx_data    <= rsh;
               rx_valid   <= 1'b1;
               rx_overrun <= 1'b0;
            end
         end else if (rx_ack && rx_valid) begin
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: directed RX vector table, TX waveform checks against a frame
// model, randomized loopback traffic and a mid-frame reset.
module tb_uart_core;

   localparam int CLK_FREQ = 160;
   localparam int BAUD     = 10;
   localparam int BPC      = CLK_FREQ / BAUD;

   logic       clk, rst, rx, tx, tx_start, tx_busy, rx_valid, rx_ack;
   logic       rx_frame_err, rx_overrun;
   logic [7:0] tx_data, rx_data;
   logic       rx_drv, loop;

   int n_vec = 0;
   int n_err = 0;
   int ferr_cnt = 0;

   assign rx = loop ? tx : rx_drv;

   uart_core #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
      .clk(clk), .rst(rst), .rx(rx), .tx(tx), .tx_start(tx_start),
      .tx_data(tx_data), .tx_busy(tx_busy), .rx_data(rx_data),
      .rx_valid(rx_valid), .rx_ack(rx_ack), .rx_frame_err(rx_frame_err),
      .rx_overrun(rx_overrun)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // count cycles in which the frame error pulse is high
   always @(posedge clk) if (rx_frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // model: a frame is {stop=1, data LSB first, start=0}, each bit BPC clocks
   task automatic send_frame(input logic [7:0] b, input int gap, input logic ack_prev,
                             input logic chk_rx);
      logic [9:0] fb;
      fb = {1'b1, b, 1'b0};
      for (int g = 0; g < gap; g++) begin
         chk("tx_idle_gap", tx, 1'b1);
         @(negedge clk);
      end
      chk("busy_before_start", tx_busy, 1'b0);
      tx_start = 1'b1;
      tx_data  = b;
      rx_ack   = ack_prev;
      @(negedge clk);
      rx_ack = 1'b0;
      for (int k = 0; k < 10 * BPC; k++) begin
         chk("tx_bit", tx, fb[k / BPC]);
         chk("tx_busy_frame", tx_busy, 1'b1);
         // requests during a frame must be ignored whatever the data
         tx_start = ($urandom_range(0, 7) == 0);
         tx_data  = 8'($urandom);
         @(negedge clk);
      end
      tx_start = 1'b0;
      chk("tx_busy_end", tx_busy, 1'b0);
      chk("tx_idle_end", tx, 1'b1);
      if (chk_rx) begin
         chk("loop_valid", rx_valid, 1'b1);
         chk("loop_data", rx_data, b);
         chk("loop_overrun", rx_overrun, 1'b0);
      end
   endtask

   task automatic drive_frame(input logic [7:0] b, input logic stop, input int hold);
      logic [9:0] bits;
      bits = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx_drv = bits[i];
         repeat (i == 9 ? hold : BPC) @(negedge clk);
      end
      rx_drv = 1'b1;
   endtask

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       glitch;
      logic       ack;
      logic       exp_valid;
      logic [7:0] exp_data;
      logic       exp_ovr;
      int         exp_ferr;
   } rxvec_t;

   rxvec_t tbl[5];

   initial begin
      logic [7:0] b;
      logic       pend;
      int         f0;

      tbl[0] = '{8'hA3, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA3, 1'b0, 0};
      tbl[1] = '{8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 0};
      tbl[2] = '{8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1, 0};
      tbl[3] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0, 1};
      tbl[4] = '{8'h7E, 1'b1, 1'b1, 1'b1, 1'b1, 8'h7E, 1'b0, 0};

      rst = 1'b1; rx_drv = 1'b1; loop = 1'b0;
      tx_start = 1'b0; tx_data = 8'h00; rx_ack = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_tx", tx, 1'b1);
      chk("rst_busy", tx_busy, 1'b0);
      chk("rst_rx_data", rx_data, 8'h00);
      chk("rst_rx_valid", rx_valid, 1'b0);
      chk("rst_ferr", rx_frame_err, 1'b0);
      chk("rst_ovr", rx_overrun, 1'b0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // fixed 0x55 pattern, line otherwise idle
      send_frame(8'h55, 0, 1'b0, 1'b0);

      // RX vector table
      for (int i = 0; i < 5; i++) begin
         if (tbl[i].glitch) begin
            f0 = ferr_cnt;
            rx_drv = 1'b0;
            repeat (5) @(negedge clk);
            rx_drv = 1'b1;
            repeat (40) @(negedge clk);
            chk("glitch_valid", rx_valid, 1'b0);
            chk("glitch_ferr", ferr_cnt - f0, 0);
         end
         f0 = ferr_cnt;
         drive_frame(tbl[i].data, tbl[i].stop, tbl[i].stop ? BPC : 40);
         repeat (4) @(negedge clk);
         chk("tbl_valid", rx_valid, tbl[i].exp_valid);
         chk("tbl_data", rx_data, tbl[i].exp_data);
         chk("tbl_ovr", rx_overrun, tbl[i].exp_ovr);
         chk("tbl_ferr_pulses", ferr_cnt - f0, tbl[i].exp_ferr);
         if (tbl[i].ack) begin
            rx_ack = 1'b1;
            @(negedge clk);
            rx_ack = 1'b0;
            chk("ack_valid", rx_valid, 1'b0);
            chk("ack_ovr", rx_overrun, 1'b0);
         end
      end

      // ack with nothing pending leaves the state alone
      rx_ack = 1'b1;
      @(negedge clk);
      rx_ack = 1'b0;
      chk("idle_ack_valid", rx_valid, 1'b0);
      chk("idle_ack_data", rx_data, 8'h7E);

      // randomized loopback traffic
      loop = 1'b1;
      pend = 1'b0;
      for (int i = 0; i < 12; i++) begin
         b = 8'($urandom);
         send_frame(b, $urandom_range(0, 3), pend, 1'b1);
         pend = 1'b1;
      end

      // back-to-back 0x00 / 0xFF, then reset in the middle of 0x3C
      send_frame(8'h00, 0, pend, 1'b1);
      send_frame(8'hFF, 0, 1'b1, 1'b1);
      f0 = ferr_cnt;
      tx_start = 1'b1; tx_data = 8'h3C; rx_ack = 1'b1;
      @(negedge clk);
      tx_start = 1'b0; rx_ack = 1'b0;
      repeat (20) @(negedge clk);
      chk("pre_rst_tx_low", tx, 1'b0);
      rst = 1'b1;
      #1;
      chk("async_rst_tx", tx, 1'b1);
      chk("async_rst_busy", tx_busy, 1'b0);
      chk("async_rst_data", rx_data, 8'h00);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (200) @(negedge clk);
      chk("post_rst_tx", tx, 1'b1);
      chk("post_rst_busy", tx_busy, 1'b0);
      chk("post_rst_valid", rx_valid, 1'b0);
      chk("post_rst_data", rx_data, 8'h00);
      chk("post_rst_ovr", rx_overrun, 1'b0);
      chk("post_rst_ferr", ferr_cnt - f0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
